// File: rtl/adc_sample_ctrl_if.sv
// Converter handshake, sample FIFO read port and status flags of adc_sample_ctrl.
// slave is the controller's view; master is the host/converter side that drives it.
interface adc_sample_ctrl_if;
  logic       enable;
  logic       nconvst;
  logic       nbusy;
  logic [7:0] adc_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       timeout_err;
  logic       busy;

  modport slave (
    input  enable, nbusy, adc_data, rd_en,
    output nconvst, rd_data, fifo_empty, fifo_full, fifo_count, overflow, timeout_err, busy
  );

  modport master (
    output enable, nbusy, adc_data, rd_en,
    input  nconvst, rd_data, fifo_empty, fifo_full, fifo_count, overflow, timeout_err, busy
  );
endinterface

// File: rtl/adc_sample_ctrl.sv
// AD7886-style converter sequencer with a 16x8 sample FIFO; `ADC_SAMPLE_TIMEOUT_EN adds the nbusy watchdog.
// nbusy rise to capture 3 clk, rd_en to rd_data 1 clk; capture never stalls, a full FIFO drops the sample and sets overflow.
module adc_sample_ctrl #(
  parameter int CONV_LOW_CYC = 50,
  parameter int ACQ_CYC      = 150,
  parameter int TIMEOUT_CYC  = 1000
) (
  input logic              clk,
  input logic              reset,
  adc_sample_ctrl_if.slave bus
);
  localparam int MAX_AB    = (CONV_LOW_CYC > ACQ_CYC) ? CONV_LOW_CYC : ACQ_CYC;
  localparam int CNT_RANGE = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W     = (CNT_RANGE > 2) ? $clog2(CNT_RANGE) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONV_LOW  = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] READ      = 3'd3;
  localparam logic [2:0] ACQ       = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             nconvst_q;
  logic             nbusy_s1, nbusy_s2, nbusy_d, nbusy_rise, seen_low;
  logic             timeout_set;

  logic [7:0] mem [16];
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;
  logic [7:0] rd_data_q;
  logic       overflow_q;
  logic       wr_req, do_wr, do_rd;

  assign nbusy_rise = nbusy_s2 & ~nbusy_d;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_nxt = CONV_LOW;
          cnt_nxt   = CNT_W'(CONV_LOW_CYC - 1);
        end
      end
      CONV_LOW: begin
        if (cnt == '0) begin
          state_nxt = WAIT_BUSY;
`ifdef ADC_SAMPLE_TIMEOUT_EN
          cnt_nxt   = CNT_W'(TIMEOUT_CYC - 1);
`else
          cnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT_BUSY: begin
        // A rise only counts once this conversion has shown nbusy low.
        if (nbusy_rise && seen_low) begin
          state_nxt = READ;
        end
`ifdef ADC_SAMPLE_TIMEOUT_EN
        else if (cnt == '0) begin
          timeout_set = 1'b1;
          state_nxt   = ACQ;
          cnt_nxt     = CNT_W'(ACQ_CYC - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
`endif
      end
      READ: begin
        state_nxt = ACQ;
        cnt_nxt   = CNT_W'(ACQ_CYC - 1);
      end
      ACQ: begin
        if (cnt == '0) begin
          if (bus.enable) begin
            state_nxt = CONV_LOW;
            cnt_nxt   = CNT_W'(CONV_LOW_CYC - 1);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      nconvst_q <= 1'b1;
      nbusy_s1  <= 1'b1;
      nbusy_s2  <= 1'b1;
      nbusy_d   <= 1'b1;
      seen_low  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      nconvst_q <= (state_nxt != CONV_LOW);
      nbusy_s1  <= bus.nbusy;
      nbusy_s2  <= nbusy_s1;
      nbusy_d   <= nbusy_s2;
      if (state_nxt == CONV_LOW && state != CONV_LOW) begin
        seen_low <= 1'b0;
      end else if (!nbusy_s2) begin
        seen_low <= 1'b1;
      end
    end
  end

`ifdef ADC_SAMPLE_TIMEOUT_EN
  logic timeout_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (timeout_set) begin
      timeout_q <= 1'b1;
    end
  end
  assign bus.timeout_err = timeout_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_req = (state == READ);
  assign do_rd  = bus.rd_en && (count != 5'd0);
  assign do_wr  = wr_req && ((count != 5'd16) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.adc_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 4'd1;
      end
      if (do_rd) begin
        rd_ptr    <= rd_ptr + 4'd1;
        rd_data_q <= mem[rd_ptr];
      end
      count <= count + {4'd0, do_wr} - {4'd0, do_rd};
      if (wr_req && !do_wr) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.nconvst    = nconvst_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.fifo_count = count;
  assign bus.fifo_empty = (count == 5'd0);
  assign bus.fifo_full  = (count == 5'd16);
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state != IDLE);
endmodule
